// File: rtl/mem_stage_hs.sv
// Memory stage between E/M and W: req/ready data-memory handshake, upstream stall, M/W register.
// Optional misaligned-access trap enabled by defining ALIGN_CHECK_EN.
module mem_stage_hs #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   m_valid,
    input  logic                   m_mem_read,
    input  logic                   m_mem_write,
    input  logic                   m_reg_write,
    input  logic                   m_mem_to_reg,
    input  logic [DATA_W-1:0]      m_alu_out,
    input  logic [DATA_W-1:0]      m_wdata,
    input  logic [REG_AW-1:0]      m_write_reg,
    output logic                   stall_m,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   mem_ready,
    output logic                   w_valid,
    output logic                   w_reg_write,
    output logic                   w_mem_to_reg,
    output logic [DATA_W-1:0]      w_read_data,
    output logic [DATA_W-1:0]      w_alu_out,
    output logic [REG_AW-1:0]      w_write_reg,
    output logic                   bus_err,
`ifdef ALIGN_CHECK_EN
    output logic                   misalign,
`endif
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StWait = 1'b1;

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

    logic [0:0]             state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic acc;
    logic timed_out;
    logic abort;
    logic misal;

`ifdef ALIGN_CHECK_EN
    localparam int unsigned OffW = $clog2(DATA_W / 8);
    logic misalign_q;

    if (OffW > 0) begin : g_off
        assign misal = m_valid & (m_mem_read | m_mem_write) & (|m_alu_out[OffW-1:0]);
    end else begin : g_no_off
        assign misal = 1'b0;
    end
    assign misalign = misalign_q;
`else
    assign misal = 1'b0;
`endif

    assign acc = m_valid & (m_mem_read | m_mem_write) & ~misal;

    // cnt_q holds the number of wait cycles already spent; it is entered as 1 from IDLE.
    assign timed_out = (state_q == StWait) ? (cnt_q == CntMax) : (CntMax == '0);
    assign abort     = (TIMEOUT != 0) & acc & ~mem_ready & timed_out;
    assign stall_m   = acc & ~mem_ready & ~abort;

    assign mem_req   = acc & ~reset;
    assign mem_we    = m_mem_write;
    assign mem_addr  = m_alu_out[ADDR_W-1:0];
    assign mem_wdata = m_wdata;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        state_d     = stall_m ? StWait : StIdle;
        cnt_d       = '0;
        stall_cnt_d = stall_cnt_q;
        if (stall_m) begin
            cnt_d = (state_q == StWait) ? cnt_q + 1'b1 : CntW'(1);
            if (~&stall_cnt_q) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // M/W boundary: a stall cycle becomes a bubble, payload fields hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_valid      <= 1'b0;
            w_reg_write  <= 1'b0;
            w_mem_to_reg <= 1'b0;
            w_read_data  <= '0;
            w_alu_out    <= '0;
            w_write_reg  <= '0;
            bus_err      <= 1'b0;
        end else if (stall_m) begin
            w_valid     <= 1'b0;
            w_reg_write <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            w_valid      <= m_valid;
            w_reg_write  <= m_valid & m_reg_write & ~abort & ~misal;
            w_mem_to_reg <= m_mem_to_reg;
            w_alu_out    <= m_alu_out;
            w_write_reg  <= m_write_reg;
            bus_err      <= abort;
            if (acc & m_mem_read & mem_ready) begin
                w_read_data <= mem_rdata;
            end
        end
    end

`ifdef ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misal;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_hs.sv
// Scoreboard bench for mem_stage_hs: stimulus pushes expected W results, a monitor pops them.
module tb_mem_stage_hs;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid, m_mem_read, m_mem_write, m_reg_write, m_mem_to_reg;
    logic [31:0] m_alu_out, m_wdata;
    logic [4:0]  m_write_reg;
    logic        stall_m, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        w_valid, w_reg_write, w_mem_to_reg;
    logic [31:0] w_read_data, w_alu_out;
    logic [4:0]  w_write_reg;
    logic        bus_err;
    logic [15:0] stall_cnt;
`ifdef ALIGN_CHECK_EN
    logic        misalign;
`endif

    mem_stage_hs #(
        .DATA_W(32), .ADDR_W(32), .REG_AW(5), .TIMEOUT(TO), .STALL_CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_mem_read(m_mem_read), .m_mem_write(m_mem_write),
        .m_reg_write(m_reg_write), .m_mem_to_reg(m_mem_to_reg),
        .m_alu_out(m_alu_out), .m_wdata(m_wdata), .m_write_reg(m_write_reg),
        .stall_m(stall_m), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .w_valid(w_valid), .w_reg_write(w_reg_write), .w_mem_to_reg(w_mem_to_reg),
        .w_read_data(w_read_data), .w_alu_out(w_alu_out), .w_write_reg(w_write_reg),
        .bus_err(bus_err),
`ifdef ALIGN_CHECK_EN
        .misalign(misalign),
`endif
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [4:0]  wreg;
        logic        berr;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_wv = 0;
    int          n_issued = 0;
    int          exp_stalls = 0;
    logic [31:0] last_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every W-valid cycle retires the oldest expected instruction.
    always @(negedge clk) begin
        if (!reset) begin
            if (w_valid) begin
                n_wv++;
                if (sb.size() == 0) begin
                    chk("w_valid_unexpected", 32'(w_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("w_reg_write", 32'(w_reg_write), 32'(e.rw));
                    chk("w_mem_to_reg", 32'(w_mem_to_reg), 32'(e.m2r));
                    chk("w_alu_out", w_alu_out, e.alu);
                    chk("w_read_data", w_read_data, e.rd);
                    chk("w_write_reg", 32'(w_write_reg), 32'(e.wreg));
                    chk("bus_err", 32'(bus_err), 32'(e.berr));
`ifdef ALIGN_CHECK_EN
                    chk("misalign", 32'(misalign), 32'(e.mis));
`endif
                end
            end else begin
                chk("bubble_reg_write", 32'(w_reg_write), 32'd0);
                chk("bubble_bus_err", 32'(bus_err), 32'd0);
            end
        end
    end

    // waits < 0: memory never answers, so the access must time out.
    task automatic issue(input logic rd, input logic wr, input logic rw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wreg,
                         input int waits, input logic [31:0] rdata);
        logic mis, acc, abort, ready, exp_stall;
        exp_t e;
        int   k;
`ifdef ALIGN_CHECK_EN
        mis = (rd | wr) && (alu[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        acc   = (rd | wr) & ~mis;
        abort = acc && (waits < 0);
        if (acc && rd && !abort) last_rd = rdata;
        e.rw = rw & ~abort & ~mis; e.m2r = m2r; e.alu = alu; e.rd = last_rd;
        e.wreg = wreg; e.berr = abort; e.mis = mis;
        sb.push_back(e);
        n_issued++;
        m_valid = 1'b1; m_mem_read = rd; m_mem_write = wr; m_reg_write = rw;
        m_mem_to_reg = m2r; m_alu_out = alu; m_wdata = wd; m_write_reg = wreg;
        k = 0;
        forever begin
            // Non-memory ops see mem_ready=1 with junk data, which must be ignored.
            ready     = acc ? (waits >= 0 && k == waits) : 1'b1;
            mem_ready = ready;
            mem_rdata = (acc && ready) ? rdata : (32'hBAD0_0000 | 32'(k));
            @(negedge clk);
            exp_stall = acc && !ready && !(abort && k == TO - 1);
            chk("stall_m", 32'(stall_m), 32'(exp_stall));
            chk("mem_req", 32'(mem_req), 32'(acc));
            if (acc) begin
                chk("mem_we", 32'(mem_we), 32'(wr));
                chk("mem_addr", mem_addr, alu);
                chk("mem_wdata", mem_wdata, wd);
            end
            if (exp_stall) exp_stalls++;
            @(posedge clk); #1;
            k++;
            if (!exp_stall) break;
            if (k > TO + 4) begin
                chk("access_bound", 32'(k), 32'(TO));
                break;
            end
        end
        m_valid = 1'b0; m_mem_read = 1'b0; m_mem_write = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        m_valid = 1'b1; m_mem_read = 1'b1; m_mem_write = 1'b0; m_reg_write = 1'b1;
        m_mem_to_reg = 1'b1; m_alu_out = 32'h10; m_wdata = '0; m_write_reg = 5'd1;
        mem_rdata = '0; mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_w_valid", 32'(w_valid), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        m_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Zero-wait back-to-back loads
        issue(1, 0, 1, 1, 32'h0, 32'h0, 5'd1, 0, 32'h1111_0001);
        issue(1, 0, 1, 1, 32'h4, 32'h0, 5'd2, 0, 32'h2222_0002);
        issue(1, 0, 1, 1, 32'h8, 32'h0, 5'd3, 0, 32'h3333_0003);
        issue(1, 0, 1, 1, 32'hC, 32'h0, 5'd4, 0, 32'h4444_0004);
        issue(0, 0, 1, 0, 32'h1234, 32'h0, 5'd9, 0, 32'hFFFF_0000);
        chk("stall_cnt_t1", 32'(stall_cnt), 32'(exp_stalls));

        // 3-wait load to r7
        issue(1, 0, 1, 1, 32'h40, 32'h0, 5'd7, 3, 32'hCAFE_F00D);
        chk("stall_cnt_t2", 32'(stall_cnt), 32'd3);

        // Timeout then a following load
        issue(1, 0, 1, 1, 32'h80, 32'h0, 5'd5, -1, 32'h0);
        issue(1, 0, 1, 1, 32'h84, 32'h0, 5'd6, 0, 32'h5555_0006);
        chk("stall_cnt_t3", 32'(stall_cnt), 32'd6);

        // Store then load, one wait each
        issue(0, 1, 0, 0, 32'h100, 32'hA5A5_5A5A, 5'd0, 1, 32'h0);
        issue(1, 0, 1, 1, 32'h100, 32'h0, 5'd3, 1, 32'hA5A5_5A5A);
        chk("stall_cnt_t4", 32'(stall_cnt), 32'd8);

`ifdef ALIGN_CHECK_EN
        issue(1, 0, 1, 1, 32'h6, 32'h0, 5'd2, 0, 32'h7777_7777);
        chk("stall_cnt_t6", 32'(stall_cnt), 32'd8);
`endif
        idle(2);

        // Reset while an access is waiting
        m_valid = 1'b1; m_mem_read = 1'b1; m_reg_write = 1'b1; m_mem_to_reg = 1'b1;
        m_alu_out = 32'h200; m_write_reg = 5'd8; mem_ready = 1'b0;
        idle(2);
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_w_valid", 32'(w_valid), 32'd0);
        chk("mid_rst_w_read_data", w_read_data, 32'd0);
        chk("mid_rst_w_alu_out", w_alu_out, 32'd0);
        chk("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("mid_rst_bus_err", 32'(bus_err), 32'd0);
        m_valid = 1'b0; m_mem_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_stalls = 0;
        last_rd = '0;
        issue(0, 0, 1, 0, 32'h300, 32'h0, 5'd4, 0, 32'h0);
        issue(1, 0, 1, 1, 32'h304, 32'h0, 5'd5, 2, 32'h6666_0005);
        chk("stall_cnt_t5", 32'(stall_cnt), 32'd2);
        idle(3);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("w_valid_count", 32'(n_wv), 32'(n_issued));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
